// File: rtl/arch_dbg_pkg.sv
// Shared types for the architectural-state debug monitor: dump FSM states,
// the streamed record layout and the auto-dump trigger bit positions.
package arch_dbg_pkg;

    localparam int DBG_XLEN   = 32;
    localparam int DBG_AREG_W = 5;
    localparam int DBG_PREG_W = 7;

    localparam int AUTO_ON_MISPREDICT = 0;
    localparam int AUTO_ON_HANG       = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_MAP = 2'd1,
        ST_RD_PRF = 2'd2,
        ST_EMIT   = 2'd3
    } dump_state_e;

    typedef struct packed {
        logic [DBG_AREG_W-1:0] areg;
        logic [DBG_PREG_W-1:0] preg;
        logic [DBG_XLEN-1:0]   data;
        logic                  last;
    } dump_rec_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: clear has priority over a saturating increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/arch_state_monitor.sv
// Debug/performance monitor: walks arch regs through rename map and PRF, streams
// (areg, preg, value) records, and keeps saturating perf counters plus a hang watchdog.
module arch_state_monitor
    import arch_dbg_pkg::*;
#(
    parameter int          XLEN       = DBG_XLEN,
    parameter int          AREG_W     = DBG_AREG_W,
    parameter int          PREG_W     = DBG_PREG_W,
    parameter int          CNT_W      = 32,
    parameter int          NUM_WATCH  = 4,
    parameter int          HANG_LIMIT = 1024,
    parameter logic [1:0]  AUTO_DUMP  = 2'b00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          commit_valid,
    input  logic                          mispredict,
    output logic [AREG_W-1:0]             map_rd_areg,
    input  logic [PREG_W-1:0]             map_rd_preg,
    output logic [PREG_W-1:0]             prf_rd_preg,
    input  logic [XLEN-1:0]               prf_rd_data,
    input  logic                          dump_req,
    input  logic                          dump_watch_only,
    input  logic [NUM_WATCH*AREG_W-1:0]   watch_areg,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [AREG_W-1:0]             dump_areg,
    output logic [PREG_W-1:0]             dump_preg,
    output logic [XLEN-1:0]               dump_data,
    output logic                          dump_last,
    output logic                          busy,
    output logic                          hang,
    output logic [CNT_W-1:0]              cycle_cnt,
    output logic [CNT_W-1:0]              commit_cnt,
    output logic [CNT_W-1:0]              mispredict_cnt
);

    localparam int NUM_AREG = 1 << AREG_W;
    localparam int WIDX_W   = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
    localparam int POS_W    = ((AREG_W > WIDX_W) ? AREG_W : WIDX_W) + 1;
    localparam int WD_W     = $clog2(HANG_LIMIT + 1);

    localparam logic [POS_W-1:0] LAST_FULL  = POS_W'(NUM_AREG - 1);
    localparam logic [POS_W-1:0] LAST_WATCH = POS_W'(NUM_WATCH - 1);
    localparam logic [WD_W-1:0]  HANG_PRE   = WD_W'(HANG_LIMIT - 1);

    dump_state_e                  state_q, state_d;
    logic [POS_W-1:0]             pos_q, pos_d;
    logic                         watch_mode_q, watch_mode_d;
    logic [NUM_WATCH*AREG_W-1:0]  watch_list_q, watch_list_d;
    dump_rec_t                    rec_q, rec_d;
    logic                         pending_q, pending_d;
    logic                         hang_q, hang_d;
    logic                         hang_prev_q, hang_prev_d;

    logic                         trig_s;
    logic                         hs_s;
    logic                         start_s;
    logic                         adv_s;
    logic                         sel_watch_s;
    logic [NUM_WATCH*AREG_W-1:0]  sel_list_s;
    logic [POS_W-1:0]             sel_pos_s;
    logic [AREG_W-1:0]            sel_areg_s;
    logic                         sel_last_s;
    logic [WD_W-1:0]              idle_cnt_s;

    function automatic logic [AREG_W-1:0] pick_areg(
        input logic                        watch,
        input logic [NUM_WATCH*AREG_W-1:0] list,
        input logic [POS_W-1:0]            pos
    );
        logic [AREG_W-1:0] a;
        a = {AREG_W{1'b0}};
        if (watch) begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                if (pos == POS_W'(i)) begin
                    a = list[i*AREG_W +: AREG_W];
                end else begin
                    a = a;
                end
            end
        end else begin
            a = pos[AREG_W-1:0];
        end
        return a;
    endfunction

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(1'b1), .count(cycle_cnt)
    );
    sat_counter #(.W(CNT_W)) u_commit_cnt (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(commit_valid), .count(commit_cnt)
    );
    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(mispredict), .count(mispredict_cnt)
    );
    sat_counter #(.W(WD_W)) u_idle_cnt (
        .clk(clk), .reset(reset), .clear(commit_valid), .inc(1'b1), .count(idle_cnt_s)
    );

    // watchdog: hang registers once the idle count is about to reach the limit
    always_comb begin
        hang_d      = hang_q;
        hang_prev_d = hang_q;
        if (commit_valid) begin
            hang_d = 1'b0;
        end else if (idle_cnt_s >= HANG_PRE) begin
            hang_d = 1'b1;
        end else begin
            hang_d = hang_q;
        end
    end

    assign trig_s = dump_req
                  | (AUTO_DUMP[AUTO_ON_MISPREDICT] & mispredict)
                  | (AUTO_DUMP[AUTO_ON_HANG] & hang_q & ~hang_prev_q);

    // dump start / advance decisions; a pending trigger restarts on the last handshake
    always_comb begin
        hs_s    = (state_q == ST_EMIT) && dump_ready;
        start_s = 1'b0;
        adv_s   = 1'b0;
        if (state_q == ST_IDLE) begin
            start_s = trig_s;
        end else if (hs_s && rec_q.last) begin
            start_s = pending_q | trig_s;
        end else begin
            start_s = 1'b0;
        end
        if (hs_s && !rec_q.last) begin
            adv_s = 1'b1;
        end else begin
            adv_s = 1'b0;
        end
    end

    // next register selection: a fresh dump samples mode/list, otherwise step the position
    always_comb begin
        sel_watch_s = watch_mode_q;
        sel_list_s  = watch_list_q;
        sel_pos_s   = pos_q + POS_W'(1);
        if (start_s) begin
            sel_watch_s = dump_watch_only;
            sel_list_s  = watch_areg;
            sel_pos_s   = {POS_W{1'b0}};
        end else begin
            sel_pos_s   = pos_q + POS_W'(1);
        end
        sel_areg_s = pick_areg(sel_watch_s, sel_list_s, sel_pos_s);
        sel_last_s = sel_watch_s ? (sel_pos_s == LAST_WATCH) : (sel_pos_s == LAST_FULL);
    end

    // dump FSM next state and record datapath
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        watch_mode_d = watch_mode_q;
        watch_list_d = watch_list_q;
        rec_d        = rec_q;
        pending_d    = pending_q;

        if (start_s) begin
            pending_d = 1'b0;
        end else if ((state_q != ST_IDLE) && trig_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (start_s || adv_s) begin
            pos_d        = sel_pos_s;
            watch_mode_d = sel_watch_s;
            watch_list_d = sel_list_s;
            rec_d.areg   = DBG_AREG_W'(sel_areg_s);
            rec_d.preg   = {DBG_PREG_W{1'b0}};
            rec_d.data   = {DBG_XLEN{1'b0}};
            rec_d.last   = sel_last_s;
            // areg 0 is hardwired zero, so it skips both lookups
            state_d      = (sel_areg_s == {AREG_W{1'b0}}) ? ST_EMIT : ST_RD_MAP;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_RD_MAP: begin
                    rec_d.preg = DBG_PREG_W'(map_rd_preg);
                    state_d    = ST_RD_PRF;
                end
                ST_RD_PRF: begin
                    rec_d.data = DBG_XLEN'(prf_rd_data);
                    state_d    = ST_EMIT;
                end
                ST_EMIT:   state_d = hs_s ? ST_IDLE : ST_EMIT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pos_q        <= {POS_W{1'b0}};
            watch_mode_q <= 1'b0;
            watch_list_q <= {(NUM_WATCH*AREG_W){1'b0}};
            rec_q        <= '{default: '0};
            pending_q    <= 1'b0;
            hang_q       <= 1'b0;
            hang_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            watch_mode_q <= watch_mode_d;
            watch_list_q <= watch_list_d;
            rec_q        <= rec_d;
            pending_q    <= pending_d;
            hang_q       <= hang_d;
            hang_prev_q  <= hang_prev_d;
        end
    end

    // lookup ports are only driven in their own phase
    always_comb begin
        map_rd_areg = {AREG_W{1'b0}};
        prf_rd_preg = {PREG_W{1'b0}};
        if (state_q == ST_RD_MAP) begin
            map_rd_areg = AREG_W'(rec_q.areg);
        end else begin
            map_rd_areg = {AREG_W{1'b0}};
        end
        if (state_q == ST_RD_PRF) begin
            prf_rd_preg = PREG_W'(rec_q.preg);
        end else begin
            prf_rd_preg = {PREG_W{1'b0}};
        end
    end

    assign dump_valid = (state_q == ST_EMIT);
    assign dump_last  = dump_valid & rec_q.last;
    assign dump_areg  = AREG_W'(rec_q.areg);
    assign dump_preg  = PREG_W'(rec_q.preg);
    assign dump_data  = XLEN'(rec_q.data);
    assign busy       = (state_q != ST_IDLE);
    assign hang       = hang_q;

endmodule

// File: doc/arch_state_monitor.md
Name: arch_state_monitor

Overview:
- Synthesizable debug/performance monitor alongside the out-of-order core; replaces bench-only hierarchical peeks into the rename map and PRF with real read ports.
- Walks the architectural register file (full sweep or a watch list) through rename map → PRF and streams (areg, preg, value) records over a valid/ready port.
- Keeps saturating cycle/commit/mispredict counters and a commit-starvation (hang) watchdog; dumps can be started by request, by mispredict, or by hang.

Parameters:
- XLEN, 32, data width of PRF values
- AREG_W, 5, architectural register index width (2^AREG_W arch regs)
- PREG_W, 7, physical register tag width
- CNT_W, 32, width of each performance counter
- NUM_WATCH, 4, number of entries in the watch list
- HANG_LIMIT, 1024, consecutive commit-free cycles that raise hang
- AUTO_DUMP, 2'b00, bit0: dump on mispredict; bit1: dump on hang rising edge

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  1  one or more instructions retired this cycle
- mispredict  in  1  branch mispredict flush pulse
- map_rd_areg  out  AREG_W  rename-map lookup index (asynchronous read)
- map_rd_preg  in  PREG_W  physical tag for map_rd_areg, valid in the same cycle
- prf_rd_preg  out  PREG_W  PRF read index (asynchronous read)
- prf_rd_data  in  XLEN  PRF value, valid in the same cycle
- dump_req  in  1  start a dump, single-cycle pulse
- dump_watch_only  in  1  sampled at dump start; 1 = watch list, 0 = all regs
- watch_areg  in  NUM_WATCH*AREG_W  packed watch list, entry 0 in the LSBs
- dump_valid  out  1  record valid
- dump_ready  in  1  consumer accepts the record
- dump_areg  out  AREG_W  record architectural index
- dump_preg  out  PREG_W  record physical tag
- dump_data  out  XLEN  record value
- dump_last  out  1  final record of the current dump
- busy  out  1  dump in progress
- hang  out  1  watchdog tripped
- cycle_cnt  out  CNT_W  cycles since reset
- commit_cnt  out  CNT_W  cycles with commit_valid
- mispredict_cnt  out  CNT_W  mispredict pulses

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, pending flag cleared. Reset mid-dump aborts with no dump_last.
- FSM states: IDLE → RD_MAP → RD_PRF → EMIT → (RD_MAP for next index | IDLE).
  - RD_MAP: drive map_rd_areg = cur index; register map_rd_preg.
  - RD_PRF: drive prf_rd_preg = latched tag; register prf_rd_data.
  - EMIT: dump_valid=1 with registered fields; hold them stable until dump_ready. On handshake, advance or return to IDLE.
- Latency: first record is valid 3 cycles after the trigger cycle. Steady state with dump_ready=1 is 1 record per 3 cycles.
- areg 0 skips the reads: preg=0, data=0, still emitted. RD_MAP/RD_PRF are bypassed, so EMIT comes 1 cycle after selection.
- Sequence:
  - Full mode: areg 0..2^AREG_W-1, ascending.
  - Watch mode: entries 0..NUM_WATCH-1 in order; duplicates are emitted twice.
- dump_last=1 only on the final EMIT.
- watch_areg and dump_watch_only are captured at dump start. Later changes are ignored.
- Triggers: dump_req, mispredict when AUTO_DUMP[0], hang rising edge when AUTO_DUMP[1].
  - Trigger while IDLE: start next cycle.
  - Trigger while busy: set one pending flag; further triggers merge into it. Pending starts a new dump the cycle after the current dump_last handshake.
  - Simultaneous triggers count as one.
- busy=1 from the cycle after the trigger until the dump_last handshake cycle inclusive.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones; no wrap. mispredict_cnt counts pulses even during a dump.
- Watchdog: idle counter resets to 0 on commit_valid, else increments, saturating.
  - hang=1 in the cycle after the idle counter reaches HANG_LIMIT.
  - hang stays set until a commit_valid; clears the cycle after it.
  - Commit on the same cycle the limit would be reached: hang is not raised.

Decomposition:
- Shared package arch_dbg_pkg: dump FSM state enum, a dump_rec_t struct (areg, preg, data, last), and AUTO_DUMP bit constants.
- One natural sub-module: sat_counter (parametrised width, inc, clear, saturate), instanced for the three perf counters and the watchdog.

Test Plan:
- Reset then 10 idle cycles, no commits → all outputs 0; cycle_cnt=10; hang=0.
- Map p(x7)=40, PRF[40]=0x0000002A; dump_req with watch_only=1, watch={7,28,0,7}, dump_ready=1 → 4 records in order (7,40,0x2A), (28,...), (0,0,0), (7,40,0x2A); dump_last on the 4th only.
- Full dump with dump_ready low for 5 cycles at record 3 → record 3 stays stable with no duplicate; 32 records total; dump_last on areg 31.
- AUTO_DUMP=2'b01; mispredict pulses at dump start and twice during the dump → mispredict_cnt=3; exactly one extra dump follows the current one.
- HANG_LIMIT=8, no commits → hang rises on the 9th cycle; with AUTO_DUMP[1] a dump starts. One commit_valid → hang clears the next cycle.
- CNT_W=4, commit_valid held 20 cycles → commit_cnt saturates at 15. Reset asserted mid-EMIT → dump_valid/busy=0 the next cycle and no dump_last.
